// File: rtl/alu_issue.sv
// alu_issue: issues one operation at a time to a chip-select/ready ALU,
// waits for its busy/done sequence and returns the captured result with its tag.
module alu_issue #(
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    input  logic [3:0]  req_tag,
    output logic        alu_cs,
    output logic [2:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic        alu_rdy,
    input  logic [15:0] alu_out,
    input  logic        alu_cout,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic        res_cout,
    output logic [3:0]  res_tag,
    output logic        res_err,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_HOLD
    } state_t;

    localparam logic [2:0]    OP_ILLEGAL  = 3'd3;
    localparam logic [TW-1:0] TIMEOUT_CNT = TW'(TIMEOUT);

    state_t        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [15:0]   a_q, a_d;
    logic [15:0]   b_q, b_d;
    logic [3:0]    tag_q, tag_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [15:0]   data_q, data_d;
    logic          cout_q, cout_d;
    logic          err_q, err_d;
    logic [TW-1:0] cnt_inc;
    logic          timeout;

    // The counter value after this cycle's increment; reaching TIMEOUT ends the wait.
    assign cnt_inc = cnt_q + TW'(1);
    assign timeout = (cnt_inc == TIMEOUT_CNT);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        tag_d   = tag_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        cout_d  = cout_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d  = req_op;
                    a_d   = req_a;
                    b_d   = req_b;
                    tag_d = req_tag;
                    if (req_op == OP_ILLEGAL) begin
                        data_d  = 16'd0;
                        cout_d  = 1'b0;
                        err_d   = 1'b1;
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (alu_rdy) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                cnt_d = cnt_inc;
                if (timeout) begin
                    data_d  = 16'd0;
                    cout_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_HOLD;
                end else if (!alu_rdy) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                cnt_d = cnt_inc;
                // A completion seen on the last allowed cycle still wins over the timeout.
                if (alu_rdy) begin
                    data_d  = alu_out;
                    cout_d  = alu_cout;
                    err_d   = 1'b0;
                    state_d = S_HOLD;
                end else if (timeout) begin
                    data_d  = 16'd0;
                    cout_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= 3'd0;
            a_q     <= 16'd0;
            b_q     <= 16'd0;
            tag_q   <= 4'd0;
            cnt_q   <= '0;
            data_q  <= 16'd0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            tag_q   <= tag_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
        end
    end

    // Gating with rst_n keeps req_ready low for the whole reset, including before the first edge.
    assign req_ready = rst_n && (state_q == S_IDLE);
    assign alu_cs    = (state_q == S_ISSUE) && alu_rdy;
    assign alu_op    = op_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign res_valid = (state_q == S_HOLD);
    assign res_data  = data_q;
    assign res_cout  = cout_q;
    assign res_tag   = tag_q;
    assign res_err   = err_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: vector table, directed corner cases and random traffic for
// alu_issue, driven against a behavioural ALU and a latency/result model.
`timescale 1ns/1ps
module tb_alu_issue;

    localparam int TIMEOUT = 8;
    localparam int TW      = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [3:0]  req_tag;
    logic        alu_cs;
    logic [2:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        alu_rdy;
    logic [15:0] alu_out;
    logic        alu_cout;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        res_cout;
    logic [3:0]  res_tag;
    logic        res_err;
    logic        busy;

    always #5 clk = ~clk;

    alu_issue #(.TIMEOUT(TIMEOUT), .TW(TW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_tag   (req_tag),
        .alu_cs    (alu_cs),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_rdy   (alu_rdy),
        .alu_out   (alu_out),
        .alu_cout  (alu_cout),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_cout  (res_cout),
        .res_tag   (res_tag),
        .res_err   (res_err),
        .busy      (busy)
    );

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  tag;
        int          n;
        int          hold;
        logic [15:0] exp_data;
        logic        exp_cout;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    function automatic logic [16:0] alu_fn(input logic [2:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
        logic [31:0] p;
        p = 32'(a) * 32'(b);
        case (op)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {a < b, a - b};
            3'd2:    return {1'b0, p[15:0]};
            3'd4:    return {1'b0, a & b};
            3'd5:    return {1'b0, a | b};
            3'd6:    return {1'b0, a ^ b};
            3'd7:    return {1'b0, ~a};
            default: return 17'd0;
        endcase
    endfunction

    // Bench ALU: rdy drops the cycle after cs is sampled and stays low for n cycles.
    int          alu_n     = 1;
    bit          alu_stuck = 1'b0;
    int          busy_left = 0;
    int          cs_count  = 0;
    int          cs_double = 0;
    logic        prev_cs   = 1'b0;
    logic [16:0] alu_res   = 17'd0;

    assign alu_rdy  = (busy_left == 0);
    assign alu_out  = alu_res[15:0];
    assign alu_cout = alu_res[16];

    always @(posedge clk) begin
        prev_cs <= alu_cs;
        if (alu_cs && prev_cs) cs_double <= cs_double + 1;
        if (alu_cs) begin
            busy_left <= alu_n;
            alu_res   <= alu_fn(alu_op, alu_a, alu_b);
            cs_count  <= cs_count + 1;
        end else if (busy_left > 0 && !alu_stuck) begin
            busy_left <= busy_left - 1;
        end
    end

    // Reference: illegal ops finish after one cycle, legal ops spend one cycle in
    // issue, then n+1 wait cycles capped at TIMEOUT, then one cycle to present.
    function automatic vec_t predict(input vec_t v);
        vec_t r;
        logic [16:0] f;
        r = v;
        f = alu_fn(v.op, v.a, v.b);
        if (v.op == 3'd3) begin
            r.exp_data = 16'd0; r.exp_cout = 1'b0; r.exp_err = 1'b1; r.exp_lat = 1;
        end else if (v.n + 1 > TIMEOUT) begin
            r.exp_data = 16'd0; r.exp_cout = 1'b0; r.exp_err = 1'b1; r.exp_lat = TIMEOUT + 2;
        end else begin
            r.exp_data = f[15:0]; r.exp_cout = f[16]; r.exp_err = 1'b0; r.exp_lat = v.n + 3;
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input bit wait_idle);
        int lat;
        int guard;
        int start_cs;
        guard = 0;
        @(negedge clk);
        while ((!req_ready || (wait_idle && !alu_rdy)) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) checkOutput("wait_for_idle", {31'd0, req_ready}, 32'd1);
        alu_n     = v.n;
        start_cs  = cs_count;
        req_valid = 1'b1;
        req_op    = v.op;
        req_a     = v.a;
        req_b     = v.b;
        req_tag   = v.tag;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = $urandom_range(0, 7);
        req_a     = 16'($urandom);
        req_b     = 16'($urandom);
        req_tag   = 4'($urandom);
        lat = 1;
        while (!res_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("latency", lat, v.exp_lat);
        checkOutput("res_data", res_data, v.exp_data);
        checkOutput("res_cout", res_cout, v.exp_cout);
        checkOutput("res_err", res_err, v.exp_err);
        checkOutput("res_tag", res_tag, v.tag);
        checkOutput("alu_cs_pulses", cs_count - start_cs, (v.op == 3'd3) ? 0 : 1);
        checkOutput("alu_a", alu_a, v.a);
        checkOutput("alu_b", alu_b, v.b);
        checkOutput("alu_op", alu_op, v.op);
        for (int i = 0; i < v.hold; i++) begin
            @(posedge clk);
            #1;
            checkOutput("hold_valid", res_valid, 1);
            checkOutput("hold_req_ready", req_ready, 0);
            checkOutput("hold_data", res_data, v.exp_data);
            checkOutput("hold_tag", res_tag, v.tag);
            checkOutput("hold_err", res_err, v.exp_err);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        checkOutput("release_valid", res_valid, 0);
        checkOutput("release_req_ready", req_ready, 1);
        checkOutput("release_busy", busy, 0);
    endtask

    vec_t vecs[9];
    vec_t v;
    int   guard;

    initial begin
        vecs[0] = '{3'd0, 16'h0003, 16'h0004, 4'd5, 2, 0,  16'h0007, 1'b0, 1'b0, 5};
        vecs[1] = '{3'd3, 16'h1234, 16'h5678, 4'd9, 2, 0,  16'h0000, 1'b0, 1'b1, 1};
        vecs[2] = '{3'd0, 16'hFFFF, 16'h0001, 4'd1, 1, 0,  16'h0000, 1'b1, 1'b0, 4};
        vecs[3] = '{3'd1, 16'h0005, 16'h0007, 4'd2, 3, 0,  16'hFFFE, 1'b1, 1'b0, 6};
        vecs[4] = '{3'd2, 16'h0100, 16'h0101, 4'd3, 7, 0,  16'h0100, 1'b0, 1'b0, 10};
        vecs[5] = '{3'd4, 16'hF0F0, 16'hFF00, 4'd4, 8, 0,  16'h0000, 1'b0, 1'b1, 10};
        vecs[6] = '{3'd5, 16'h00F0, 16'h0F00, 4'd6, 2, 10, 16'h0FF0, 1'b0, 1'b0, 5};
        vecs[7] = '{3'd6, 16'h1234, 16'hFFFF, 4'd7, 1, 0,  16'hEDCB, 1'b0, 1'b0, 4};
        vecs[8] = '{3'd7, 16'h00FF, 16'h0000, 4'd8, 4, 1,  16'hFF00, 1'b0, 1'b0, 7};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_a     = 16'd0;
        req_b     = 16'd0;
        req_tag   = 4'd0;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_req_ready", req_ready, 0);
        checkOutput("reset_res_valid", res_valid, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_alu_cs", alu_cs, 0);
        checkOutput("reset_res_data", res_data, 0);
        checkOutput("reset_res_err", res_err, 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("first_req_ready", req_ready, 1);

        for (int i = 0; i < 9; i++) applyStimulus(vecs[i], 1'b1);

        $display("[TB] timeout with an ALU that never finishes");
        alu_stuck = 1'b1;
        v = '{3'd0, 16'h0042, 16'h0001, 4'hC, 3, 2, 16'h0000, 1'b0, 1'b1, 10};
        applyStimulus(v, 1'b1);
        alu_stuck = 1'b0;

        $display("[TB] reset during WAIT_DONE, then issue to a still-busy ALU");
        guard = 0;
        @(negedge clk);
        while (!alu_rdy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        alu_n     = 6;
        req_valid = 1'b1;
        req_op    = 3'd0;
        req_a     = 16'h1111;
        req_b     = 16'h2222;
        req_tag   = 4'd3;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("mid_busy", busy, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midrst_res_valid", res_valid, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_req_ready", req_ready, 0);
        checkOutput("midrst_res_data", res_data, 0);
        checkOutput("midrst_res_tag", res_tag, 0);
        checkOutput("midrst_alu_a", alu_a, 0);
        checkOutput("midrst_alu_b", alu_b, 0);
        checkOutput("midrst_alu_op", alu_op, 0);
        checkOutput("midrst_alu_cs", alu_cs, 0);
        checkOutput("midrst_res_cout", res_cout, 0);
        checkOutput("midrst_res_err", res_err, 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("midrst_req_ready_after", req_ready, 1);
        checkOutput("midrst_no_valid", res_valid, 0);
        v = '{3'd0, 16'h0010, 16'h0020, 4'hA, 1, 0, 16'h0030, 1'b0, 1'b0, 6};
        applyStimulus(v, 1'b0);

        $display("[TB] random traffic");
        for (int i = 0; i < 40; i++) begin
            v.op   = 3'($urandom_range(0, 7));
            v.a    = 16'($urandom);
            v.b    = 16'($urandom);
            v.tag  = 4'($urandom);
            v.n    = int'($urandom_range(1, 9));
            v.hold = int'($urandom_range(0, 3));
            v      = predict(v);
            applyStimulus(v, 1'b1);
        end

        checkOutput("cs_single_pulse", cs_double, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/alu_issue.md
# alu_issue

Initiator side of the ALU chip-select/ready handshake. It accepts one operation at a time from the decode stage on a valid/ready port and holds the operands and opcode stable. It pulses `alu_cs`, follows the ALU's `rdy` low-then-high sequence, then captures the result and carry. The result is presented downstream with its tag. The block sits between instruction decode and register writeback, and is the only driver of the ALU's `A`, `B`, `op` and `cs` inputs.

## Interface
Parameters:
- `TIMEOUT`, 255: maximum cycles spent in WAIT_BUSY plus WAIT_DONE before the operation is abandoned.
- `TW`, 8: width of the timeout counter. Must satisfy `TIMEOUT < 2**TW`.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request; high only in IDLE.
- `req_op`  in  3  ALU opcode: 0 = add, 1 = sub, 2 = mul, 4–7 = logic; 3 is illegal.
- `req_a`, `req_b`  in  16 each  operands.
- `req_tag`  in  4  destination tag, returned with the result.
- `alu_cs`  out  1  chip select to the ALU.
- `alu_op`  out  3  opcode driven to the ALU.
- `alu_a`, `alu_b`  out  16 each  operands driven to the ALU.
- `alu_rdy`  in  1  ALU ready; high when idle, low while busy, high again when done.
- `alu_out`  in  16  ALU result.
- `alu_cout`  in  1  ALU carry out.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  downstream accepts the result.
- `res_data`  out  16  captured result.
- `res_cout`  out  1  captured carry.
- `res_tag`  out  4  tag of the request that produced the result.
- `res_err`  out  1  1 = illegal opcode or timeout.
- `busy`  out  1  high in every state except IDLE.

## Operation
States and transitions:
- **IDLE**: `req_ready`=1. On `req_valid`: latch op, a, b and tag.
  - op==3 → HOLD with `res_err`=1, `res_data`=0, `res_cout`=0. The ALU is never selected.
  - otherwise → ISSUE.
- **ISSUE**: wait until `alu_rdy`=1, then drive `alu_cs`=1 for exactly that one cycle → WAIT_BUSY. While `alu_rdy`=0, `alu_cs`=0 and the block stays in ISSUE; ISSUE is not counted toward the timeout.
- **WAIT_BUSY**: `alu_cs`=0.
  - `alu_rdy`=0 sampled → WAIT_DONE.
  - timeout → HOLD with error.
- **WAIT_DONE**:
  - `alu_rdy`=1 sampled → capture `alu_out` and `alu_cout`, `res_err`=0 → HOLD.
  - timeout → HOLD with `res_err`=1, `res_data`=0.
- **HOLD**: `res_valid`=1, all `res_*` outputs stable. On `res_ready`=1 → IDLE.

Data-path rules:
- `alu_a`, `alu_b` and `alu_op` come directly from the operand registers. They are stable from the cycle after acceptance until the next acceptance.
- The timeout counter clears on entry to WAIT_BUSY and increments each cycle in WAIT_BUSY or WAIT_DONE. A timeout occurs when the counter equals `TIMEOUT` without completion.
- Results are passed through unmodified; there is no width change.

## Timing
Reset (`rst_n`=0 sampled at an edge):
- state goes to IDLE.
- `alu_cs`, `res_valid`, `res_err`, `res_cout` and `busy` are 0.
- `res_data`, `res_tag`, `alu_a`, `alu_b` and `alu_op` are 0.
- `req_ready` is 0 while `rst_n`=0 and 1 in the first cycle after reset is released.
- Reset mid-operation abandons the operation with no result. The ALU may still be busy, and ISSUE's `alu_rdy` gate covers that case.

Cycle behaviour:
- Acceptance at edge E0 → `alu_cs`=1 during cycle E0→E1 (when the ALU is idle).
- E1 → WAIT_BUSY. The ALU drops `rdy` combinationally from its state, so `alu_rdy`=0 is visible in cycle E1→E2.
- `res_valid` rises in the cycle after the first edge at which WAIT_DONE samples `alu_rdy`=1.
- Minimum latency from acceptance to `res_valid` is 4 cycles.
- Illegal opcode: `res_valid` rises 1 cycle after acceptance.
- When `res_valid` and `res_ready` are both 1 at an edge, the next cycle is IDLE with `req_ready`=1. There is no back-to-back acceptance in the HOLD cycle.
- `alu_cs` is never high for two consecutive cycles, and never high outside ISSUE.

## Test plan
Bench ALU model: `rdy` drops 1 cycle after `cs` is sampled, rises after N busy cycles, and stays high.
- **Add, N=2**: op=0, a=0x0003, b=0x0004, tag=5 → one `alu_cs` pulse; `res_valid` after 5 cycles; `res_data`=0x0007, `res_tag`=5, `res_err`=0.
- **Illegal opcode**: op=3 → `alu_cs` never asserts; `res_valid` after 1 cycle with `res_err`=1, `res_data`=0.
- **Timeout**: `TIMEOUT`=8; the model never raises `rdy` → `res_err`=1 after 8 wait cycles; `alu_cs` was pulsed exactly once.
- **Back-pressure**: `res_ready`=0 for 10 cycles → `res_*` outputs held constant, `req_ready`=0 throughout; `res_ready`=1 → IDLE the next cycle.
- **ALU still busy**: issue while the model holds `rdy`=0 → `alu_cs` is delayed until `rdy`=1; no timeout is reported.
- **Reset mid-operation**: `rst_n`=0 in WAIT_DONE → all outputs at their reset values the next cycle; no `res_valid`.
